// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep sequencer: FSM state encodings and
// the golden reference function that the gate pair is judged against.
package gate_sweep_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned MAX_N_IN = 16;

  // Golden NAND over the low n bits of v.
  function automatic logic golden_nand(input logic [MAX_N_IN-1:0] v,
                                       input int unsigned n);
    logic all_ones;
    all_ones = 1'b1;
    for (int unsigned i = 0; i < MAX_N_IN; i++) begin
      if (i < n) all_ones = all_ones & v[i];
    end
    return ~all_ones;
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Loadable down-counter that measures how long a vector has been held.
// expired is high once the count has run down to zero.
module settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int unsigned W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE - 1);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives every input vector into a gate pair,
// compares both implementations with the golden NAND and reports the result.
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            a_in,
  input  logic            b_in,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_vld
);

  localparam logic [N_IN-1:0] VEC_MAX = '1;
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE = (N_IN + 1)'(1);

  logic [1:0] state;
  logic       expired;
  logic       timer_load;
  logic       fail;

  assign busy = (state == S_APPLY) || (state == S_CHECK);
  assign fail = (a_in != b_in) || (a_in != golden_nand(MAX_N_IN'(vec), N_IN));

  // Timer restarts whenever a fresh vector begins its hold period.
  assign timer_load = !abort &&
                      (((state == S_IDLE) && start) ||
                       ((state == S_CHECK) && (vec != VEC_MAX)));

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      vec           <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vec <= '0;
      first_err_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        // Abort keeps the partial error record but drops the verdict.
        state <= S_IDLE;
        vec   <= '0;
        pass  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state         <= S_APPLY;
              vec           <= '0;
              err_cnt       <= '0;
              first_err_vld <= 1'b0;
              pass          <= 1'b0;
            end
          end
          S_APPLY: begin
            if (expired) state <= S_CHECK;
          end
          S_CHECK: begin
            if (fail) begin
              err_cnt <= err_cnt + ERR_ONE;
              if (!first_err_vld) begin
                first_err_vec <= vec;
                first_err_vld <= 1'b1;
              end
            end
            if (vec == VEC_MAX) begin
              state <= S_DONE;
              pass  <= (err_cnt == '0) && !fail;
            end else begin
              state <= S_APPLY;
              vec   <= vec + VEC_ONE;
            end
          end
          default: begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: two instances (SETTLE=1 and 3)
// against a cycle-index model, plus directed literal scenarios.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   mode  = 0;   // 0 good, 1 B stuck-at-1, 2 A is AND, 3 random outputs
  logic rnd_a = 1'b0;
  logic rnd_b = 1'b0;

  logic [1:0] vec_o  [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       pass_o [2];
  logic [2:0] err_o  [2];
  logic [1:0] fvec_o [2];
  logic       fvld_o [2];
  logic       a_sig  [2];
  logic       b_sig  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic impl_a(int m, logic [1:0] v, logic r);
    if (m == 2) return &v;
    if (m == 3) return r;
    return ~&v;
  endfunction

  function automatic logic impl_b(int m, logic [1:0] v, logic r);
    if (m == 1) return 1'b1;
    if (m == 3) return r;
    return ~&v;
  endfunction

  assign a_sig[0] = impl_a(mode, vec_o[0], rnd_a);
  assign b_sig[0] = impl_b(mode, vec_o[0], rnd_b);
  assign a_sig[1] = impl_a(mode, vec_o[1], rnd_a);
  assign b_sig[1] = impl_b(mode, vec_o[1], rnd_b);

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .a_in(a_sig[0]), .b_in(b_sig[0]), .vec(vec_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .pass(pass_o[0]), .err_cnt(err_o[0]),
    .first_err_vec(fvec_o[0]), .first_err_vld(fvld_o[0])
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .a_in(a_sig[1]), .b_in(b_sig[1]), .vec(vec_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .pass(pass_o[1]), .err_cnt(err_o[1]),
    .first_err_vec(fvec_o[1]), .first_err_vld(fvld_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sweep is described by j = clock edges since the accepting edge.
  // With P = SETTLE+1 cycles per vector: vector j/P is applied for j < 4P,
  // the vector is judged on the edge leaving j%P == P-1, j == 4P is the
  // completion cycle and the done pulse is visible at j == 4P+1.
  bit m_valid = 1'b0;
  bit m_run   [2] = '{0, 0};
  int m_j     [2] = '{0, 0};
  int m_err   [2] = '{0, 0};
  int m_fvec  [2] = '{0, 0};
  bit m_fvld  [2] = '{0, 0};
  bit m_pass  [2] = '{0, 0};
  bit m_done  [2] = '{0, 0};
  int m_vhold [2] = '{0, 0};

  function automatic int per(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int exp_vec(int i);
    if (m_run[i] && m_j[i] < 4 * per(i)) return m_j[i] / per(i);
    if (m_run[i]) return 3;
    return m_vhold[i];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_run[i] = 0; m_j[i] = 0; m_err[i] = 0; m_fvec[i] = 0;
        m_fvld[i] = 0; m_pass[i] = 0; m_done[i] = 0; m_vhold[i] = 0;
      end else begin
        m_done[i] = 0;
        if (m_run[i] && abort) begin
          m_run[i] = 0; m_vhold[i] = 0; m_pass[i] = 0;
        end else if (m_run[i]) begin
          if (m_j[i] < 4 * per(i) && (m_j[i] % per(i)) == per(i) - 1) begin
            logic [1:0] v;
            logic a, b;
            v = 2'(m_j[i] / per(i));
            a = impl_a(mode, v, rnd_a);
            b = impl_b(mode, v, rnd_b);
            if (a != b || a != ~&v) begin
              m_err[i]++;
              if (!m_fvld[i]) begin m_fvld[i] = 1; m_fvec[i] = int'(v); end
            end
            if (m_j[i] == 4 * per(i) - 1) m_pass[i] = (m_err[i] == 0);
          end else if (m_j[i] == 4 * per(i)) begin
            m_done[i] = 1; m_run[i] = 0; m_vhold[i] = 3;
          end
          m_j[i]++;
        end else if (start && !abort) begin
          m_run[i] = 1; m_j[i] = 0; m_err[i] = 0; m_fvld[i] = 0; m_pass[i] = 0;
        end
      end
    end
    if (reset) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d.vec", i),  32'(vec_o[i]),  32'(exp_vec(i)));
        check($sformatf("dut%0d.busy", i), 32'(busy_o[i]), 32'(m_run[i] && m_j[i] < 4 * per(i)));
        check($sformatf("dut%0d.done", i), 32'(done_o[i]), 32'(m_done[i]));
        check($sformatf("dut%0d.pass", i), 32'(pass_o[i]), 32'(m_pass[i]));
        check($sformatf("dut%0d.err_cnt", i), 32'(err_o[i]), 32'(m_err[i]));
        check($sformatf("dut%0d.first_err_vld", i), 32'(fvld_o[i]), 32'(m_fvld[i]));
        check($sformatf("dut%0d.first_err_vec", i), 32'(fvec_o[i]), 32'(m_fvec[i]));
      end
    end
  end

  // ---------------- directed helpers ----------------
  int vec_seq [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input bit pulse_mid, output int lat1, output int lat3);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat1 = -1;
    lat3 = -1;
    vec_seq[0] = int'(vec_o[0]);
    for (int c = 1; c <= 30; c++) begin
      start = (pulse_mid && c == 3);
      tick();
      if (c < 8) vec_seq[c] = int'(vec_o[0]);
      if (done_o[0] === 1'b1 && lat1 < 0) lat1 = c;
      if (done_o[1] === 1'b1 && lat3 < 0) lat3 = c;
    end
    start = 1'b0;
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (done_o[0] !== 1'b0 || done_o[1] !== 1'b0) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat1, lat3;

    // 1. reset held two cycles
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("reset.vec", 32'(vec_o[0]), 32'd0);
    check("reset.busy", 32'(busy_o[0]), 32'd0);
    check("reset.done", 32'(done_o[0]), 32'd0);
    check("reset.pass", 32'(pass_o[0]), 32'd0);
    check("reset.err_cnt", 32'(err_o[0]), 32'd0);
    check("reset.first_err_vld", 32'(fvld_o[0]), 32'd0);
    tick();

    // 2. both implementations correct
    mode = 0;
    run_sweep(1'b0, lat1, lat3);
    for (int c = 0; c < 8; c++) check($sformatf("good.vec_seq%0d", c), 32'(vec_seq[c]), 32'(c / 2));
    check("good.latency_s1", 32'(lat1), 32'd9);
    check("good.latency_s3", 32'(lat3), 32'd17);
    check("good.err_cnt", 32'(err_o[0]), 32'd0);
    check("good.pass", 32'(pass_o[0]), 32'd1);

    // 3. B stuck at 1
    mode = 1;
    run_sweep(1'b0, lat1, lat3);
    check("stuck.err_cnt", 32'(err_o[0]), 32'd1);
    check("stuck.first_err_vec", 32'(fvec_o[0]), 32'd3);
    check("stuck.first_err_vld", 32'(fvld_o[0]), 32'd1);
    check("stuck.pass", 32'(pass_o[0]), 32'd0);

    // 4. A replaced by AND
    mode = 2;
    run_sweep(1'b0, lat1, lat3);
    check("and.latency_s3", 32'(lat3), 32'd17);
    check("and.err_cnt_s3", 32'(err_o[1]), 32'd4);
    check("and.first_err_vec_s3", 32'(fvec_o[1]), 32'd0);
    check("and.pass_s3", 32'(pass_o[1]), 32'd0);
    check("and.err_cnt_s1", 32'(err_o[0]), 32'd4);

    // 5. abort during CHECK of vec=2, then restart
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort.pre_vec", 32'(vec_o[0]), 32'd2);
    check("abort.pre_busy", 32'(busy_o[0]), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.busy", 32'(busy_o[0]), 32'd0);
    check("abort.vec", 32'(vec_o[0]), 32'd0);
    expect_no_done("abort.no_done", 15);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart.vec", 32'(vec_o[0]), 32'd0);
    check("restart.err_cnt", 32'(err_o[0]), 32'd0);
    check("restart.busy", 32'(busy_o[0]), 32'd1);
    repeat (30) tick();

    // 6. start while busy has no effect; reset mid-APPLY
    run_sweep(1'b1, lat1, lat3);
    check("busy_start.latency_s1", 32'(lat1), 32'd9);
    check("busy_start.latency_s3", 32'(lat3), 32'd17);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset.busy", 32'(busy_o[0]), 32'd0);
    check("midreset.vec", 32'(vec_o[0]), 32'd0);
    check("midreset.err_cnt", 32'(err_o[0]), 32'd0);
    check("midreset.pass", 32'(pass_o[0]), 32'd0);
    expect_no_done("midreset.no_done", 15);

    // randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 199) == 0);
      rnd_a = 1'($urandom_range(0, 1));
      rnd_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) mode = int'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
